// File: rtl/ms_phase_timer.sv
// Millisecond phase timer: synchronises the 1 kHz timebase, emits tick_ms,
// runs a loadable/holdable countdown and flags a stalled timebase.
module ms_phase_timer #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             clk_1KHz,
    input  logic             start,
    input  logic [CNT_W-1:0] duration_ms,
    input  logic             hold,
    input  logic             abort,
    output logic             tick_ms,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining_ms,
    output logic             tick_lost
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_PRE = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_tick;
    logic [WD_W-1:0]        r_wd;
    logic                   r_lost;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_rem, w_rem_nxt;
    logic                   r_done, w_done_nxt;

    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Timebase synchroniser and rising-edge detector.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_sync[0] <= clk_1KHz;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_prev <= w_sync_out;
            r_tick <= w_sync_out & ~r_prev;
        end
    end

    // Watchdog saturates at WD_MAX; tick_lost latches on the cycle it gets there.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_wd   <= '0;
            r_lost <= 1'b0;
        end else if (r_tick) begin
            r_wd <= '0;
        end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + WD_W'(1);
            if (r_wd == WD_PRE)
                r_lost <= 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        if (abort) begin
            // abort outranks start even in IDLE, where it simply changes nothing
            if (r_state != S_IDLE) begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
            end
        end else if (start) begin
            if (duration_ms != '0) begin
                w_state_nxt = S_RUN;
                w_rem_nxt   = duration_ms;
            end else begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
                w_done_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (hold) begin
                        w_state_nxt = S_HOLD;
                    end else if (r_tick) begin
                        if (r_rem > CNT_W'(1)) begin
                            w_rem_nxt = r_rem - CNT_W'(1);
                        end else if (r_rem == CNT_W'(1)) begin
                            w_rem_nxt   = '0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold)
                        w_state_nxt = S_RUN;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign tick_ms      = r_tick;
    assign busy         = (r_state == S_RUN) || (r_state == S_HOLD);
    assign done         = r_done;
    assign remaining_ms = r_rem;
    assign tick_lost    = r_lost;
endmodule

// File: tb/tb_ms_phase_timer.sv
// Directed bench for ms_phase_timer with a shortened timebase and watchdog.
module tb_ms_phase_timer;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 16;
    localparam int TMO         = 60;
    localparam int HALF        = 10;   // tick every 2*HALF cycles

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_1k = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] dur = '0;
    logic             hold = 1'b0;
    logic             abort = 1'b0;
    logic             tick_ms, busy, done, tick_lost;
    logic [CNT_W-1:0] rem;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  osc_en = 1'b0;
    int  osc_cnt = 0;

    ms_phase_timer #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_100MHz(clk), .rst(rst), .clk_1KHz(clk_1k), .start(start),
        .duration_ms(dur), .hold(hold), .abort(abort), .tick_ms(tick_ms),
        .busy(busy), .done(done), .remaining_ms(rem), .tick_lost(tick_lost)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (osc_en) begin
            osc_cnt++;
            if (osc_cnt == HALF) begin
                osc_cnt = 0;
                clk_1k  = ~clk_1k;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        while (tick_ms !== 1'b1 && n < 4*HALF) begin
            step();
            n++;
        end
        chk("tick_seen", {31'd0, tick_ms}, 32'd1);
    endtask

    initial begin
        int n;
        // 1: reset state, latency, width, period
        repeat (3) step();
        chk("rst_tick", {31'd0, tick_ms}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rem", 32'(rem), 0);
        chk("rst_lost", {31'd0, tick_lost}, 0);
        rst = 1'b0;
        step();
        clk_1k = 1'b1;
        step(); chk("lat_e0", {31'd0, tick_ms}, 0);
        step(); chk("lat_e1", {31'd0, tick_ms}, 0);
        step(); chk("lat_e2", {31'd0, tick_ms}, 1);
        step(); chk("tick_width", {31'd0, tick_ms}, 0);
        clk_1k = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(); chk("fall_no_tick", {31'd0, tick_ms}, 0);
        end
        osc_cnt = 0;
        osc_en  = 1'b1;
        wait_tick();
        step(); chk("tick_width2", {31'd0, tick_ms}, 0);
        n = 1;
        while (tick_ms !== 1'b1 && n < 100) begin step(); n++; end
        chk("tick_period", 32'(n), 2*HALF);
        step();

        // 2: countdown of 5
        start = 1'b1; dur = 16'd5;
        step();
        start = 1'b0;
        chk("t2_busy", {31'd0, busy}, 1);
        chk("t2_rem5", 32'(rem), 5);
        for (int k = 4; k >= 0; k--) begin
            wait_tick();
            step();
            chk("t2_rem", 32'(rem), 32'(k));
            chk("t2_done", {31'd0, done}, (k == 0) ? 32'd1 : 32'd0);
            chk("t2_busy", {31'd0, busy}, (k == 0) ? 32'd0 : 32'd1);
        end
        step(); chk("t2_done_once", {31'd0, done}, 0);

        // 3: hold across two ticks
        start = 1'b1; dur = 16'd3;
        step();
        start = 1'b0;
        wait_tick(); step();
        chk("t3_rem2", 32'(rem), 2);
        hold = 1'b1;
        wait_tick(); step();
        chk("t3_hold_a", 32'(rem), 2);
        chk("t3_hold_busy", {31'd0, busy}, 1);
        wait_tick(); step();
        chk("t3_hold_b", 32'(rem), 2);
        hold = 1'b0;
        step();
        wait_tick(); step();
        chk("t3_rem1", 32'(rem), 1);
        chk("t3_nodone", {31'd0, done}, 0);
        wait_tick(); step();
        chk("t3_rem0", 32'(rem), 0);
        chk("t3_done", {31'd0, done}, 1);

        // 4: abort, zero-length start, restart
        start = 1'b1; dur = 16'd9;
        step();
        start = 1'b0;
        wait_tick(); step();
        wait_tick(); step();
        chk("t4_rem7", 32'(rem), 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_ab_busy", {31'd0, busy}, 0);
        chk("t4_ab_rem", 32'(rem), 0);
        chk("t4_ab_done", {31'd0, done}, 0);
        step(); chk("t4_ab_done2", {31'd0, done}, 0);
        start = 1'b1; dur = 16'd0;
        step();
        start = 1'b0;
        chk("t4_z_done", {31'd0, done}, 1);
        chk("t4_z_busy", {31'd0, busy}, 0);
        step(); chk("t4_z_once", {31'd0, done}, 0);
        start = 1'b1; dur = 16'd10;
        step();
        start = 1'b0;
        wait_tick(); step();
        chk("t4_rem9", 32'(rem), 9);
        start = 1'b1; dur = 16'd4;
        step();
        start = 1'b0;
        chk("t4_reload", 32'(rem), 4);
        chk("t4_reload_busy", {31'd0, busy}, 1);

        // 5: stalled timebase
        wait_tick();
        osc_en = 1'b0;
        clk_1k = 1'b0;
        for (int i = 0; i < TMO; i++) step();
        chk("t5_lost_early", {31'd0, tick_lost}, 0);
        step();
        chk("t5_lost", {31'd0, tick_lost}, 1);
        osc_cnt = 0;
        osc_en  = 1'b1;
        wait_tick(); step();
        chk("t5_sticky", {31'd0, tick_lost}, 1);

        // 6: reset coincident with a tick mid-countdown
        start = 1'b1; dur = 16'd5;
        step();
        start = 1'b0;
        wait_tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_rem", 32'(rem), 0);
        chk("t6_done", {31'd0, done}, 0);
        chk("t6_lost", {31'd0, tick_lost}, 0);
        step();
        chk("t6_done2", {31'd0, done}, 0);
        chk("t6_busy2", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
